// File: rtl/panda_seq_shifter.sv
// ---------------------------------------------------------------------------
// panda_seq_shifter
//
// Sequential barrel-shifter replacement. It shifts one bit per clock, so an
// amount of N takes N+1 cycles from accept to result. A valid/ready handshake
// is used on both sides. The result is held in DONE until the consumer takes
// it. kill_i aborts any operation. rst_ni is a synchronous, active-low reset.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   kill_i        synchronous abort, returns to IDLE, result discarded
//   valid_i       request valid
//   ready_o       request can be accepted (IDLE and not in reset)
//   left_i        1 = shift left, 0 = shift right
//   arithmetic_i  1 = sign-fill on right shift (ignored for left)
//   operand_i     value to shift
//   amount_i      shift distance
//   valid_o       result_o valid (DONE)
//   ready_i       consumer accepts result
//   result_o      shifted value, holds its last value outside DONE
//   busy_o        operation in flight (SHIFT or DONE)
// ---------------------------------------------------------------------------
module panda_seq_shifter #(
  parameter int Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     kill_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     left_i,
  input  logic                     arithmetic_i,
  input  logic [Width-1:0]         operand_i,
  input  logic [$clog2(Width)-1:0] amount_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [Width-1:0]         result_o,
  output logic                     busy_o
);

  localparam int CntW = $clog2(Width);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e            r_state;
  state_e            w_next_state;
  logic [Width-1:0]  r_work;
  logic [Width-1:0]  r_result;
  logic [CntW-1:0]   r_count;
  logic              r_left;
  logic              r_fill;

  logic              w_accept;
  logic              w_last_step;
  logic [Width-1:0]  w_step;

  // ready_o is gated by rst_ni directly so it drops in the reset cycle itself.
  assign ready_o  = (r_state == ST_IDLE) && rst_ni;
  assign valid_o  = (r_state == ST_DONE);
  assign busy_o   = (r_state != ST_IDLE);
  assign result_o = r_result;

  assign w_accept    = valid_i && ready_o && !kill_i;
  assign w_last_step = (r_count == CntW'(1));

  // The fill bit is resolved at capture time: it is the operand sign only for
  // an arithmetic right shift, otherwise zero.
  assign w_step = r_left ? {r_work[Width-2:0], 1'b0}
                         : {r_fill, r_work[Width-1:1]};

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = (amount_i == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_step) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Abort overrides every handshake.
    if (kill_i) w_next_state = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Datapath: capture, per-cycle shift, result hold
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_work   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
    end else if (kill_i) begin
      // Working data is dead once aborted; result_o keeps its last value.
      r_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_work  <= operand_i;
            r_count <= amount_i;
            r_left  <= left_i;
            r_fill  <= arithmetic_i && !left_i && operand_i[Width-1];
            if (amount_i == '0) r_result <= operand_i;
          end
        end
        ST_SHIFT: begin
          r_work  <= w_step;
          r_count <= r_count - CntW'(1);
          if (w_last_step) r_result <= w_step;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panda_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_panda_seq_shifter
//
// Directed and randomized checks of panda_seq_shifter against a plain
// arithmetic shift model. Inputs are driven and outputs sampled 1 time unit
// after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_panda_seq_shifter;

  localparam int W  = 32;
  localparam int AW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          kill_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          left_i = 1'b0;
  logic          arithmetic_i = 1'b0;
  logic [W-1:0]  operand_i = '0;
  logic [AW-1:0] amount_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [W-1:0]  result_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  panda_seq_shifter #(.Width(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .kill_i       (kill_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .left_i       (left_i),
    .arithmetic_i (arithmetic_i),
    .operand_i    (operand_i),
    .amount_i     (amount_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] op, input int amt,
                                         input logic left, input logic arith);
    if (left)       return op << amt;
    else if (arith) return W'($signed(op) >>> amt);
    else            return op >> amt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    operand_i    = $urandom;
    amount_i     = AW'($urandom);
    left_i       = 1'($urandom);
    arithmetic_i = 1'($urandom);
  endtask

  task automatic accept(input logic [W-1:0] op, input int amt, input logic left, input logic arith);
    operand_i    = op;
    amount_i     = AW'(amt);
    left_i       = left;
    arithmetic_i = arith;
    valid_i      = 1'b1;
    tick();
    valid_i = 1'b0;
    scramble_inputs();
  endtask

  // Full transaction: accept, measure latency, check result, optionally
  // stall the consumer, then consume and confirm return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] op, input int amt,
                        input logic left, input logic arith, input int hold);
    int lat;
    logic [W-1:0] exp;
    exp = model(op, amt, left, arith);
    check({tag, ":ready_before"}, W'(ready_o), W'(1));
    accept(op, amt, left, arith);
    lat = 1;
    while (!valid_o && lat <= W + 4) begin
      tick();
      lat++;
    end
    check({tag, ":latency"}, W'(lat), W'(amt + 1));
    check({tag, ":result"}, result_o, exp);
    repeat (hold) tick();
    if (hold > 0) check({tag, ":held"}, result_o, exp);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, ":idle_after"}, {30'd0, valid_o, ready_o}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int seen;
    // ---------------- reset ----------------
    #1;
    check("reset:ready_low", W'(ready_o), W'(0));
    tick();
    tick();
    check("reset:valid", W'(valid_o), W'(0));
    check("reset:result", result_o, '0);
    check("reset:busy", W'(busy_o), W'(0));
    check("reset:ready_low2", W'(ready_o), W'(0));
    rst_ni = 1'b1;
    #1;
    check("reset:ready_release", W'(ready_o), W'(1));

    // ---------------- directed vectors ----------------
    run_op("lsr5",    32'h0034543B, 5,  1'b0, 1'b0, 0);
    check("lsr5:value", result_o, 32'h0001A2A1);
    run_op("lsl5",    32'h0034543B, 5,  1'b1, 1'b0, 0);
    check("lsl5:value", result_o, 32'h068A8760);
    run_op("lsl24",   32'hFFBD7FA6, 24, 1'b1, 1'b0, 0);
    check("lsl24:value", result_o, 32'hA6000000);
    run_op("asr8",    32'hFFBD7FA6, 8,  1'b0, 1'b1, 0);
    check("asr8:value", result_o, 32'hFFFFBD7F);
    run_op("lsr8",    32'hFFBD7FA6, 8,  1'b0, 1'b0, 0);
    check("lsr8:value", result_o, 32'h00FFBD7F);
    run_op("amt0",    32'hFFBD7FA6, 0,  1'b0, 1'b1, 0);
    check("amt0:value", result_o, 32'hFFBD7FA6);
    run_op("asr31",   32'h80000000, 31, 1'b0, 1'b1, 0);
    run_op("lsl31",   32'h00000001, 31, 1'b1, 1'b1, 1);

    // ---------------- backpressure ----------------
    accept(32'h12345678, 4, 1'b0, 1'b0);
    seen = 0;
    while (!valid_o && seen < 40) begin
      tick();
      seen++;
    end
    for (int i = 0; i < 10; i++) begin
      valid_i   = 1'b1;
      operand_i = $urandom;
      amount_i  = AW'($urandom);
      tick();
      check("bp:valid", W'(valid_o), W'(1));
      check("bp:result", result_o, 32'h01234567);
      check("bp:ready_low", W'(ready_o), W'(0));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("bp:idle", {30'd0, busy_o, ready_o}, {30'd0, 1'b0, 1'b1});
    tick();
    check("bp:not_queued", W'(busy_o), W'(0));

    // ---------------- kill mid-shift ----------------
    accept(32'hDEADBEEF, 20, 1'b0, 1'b1);   // now in cycle c+1
    tick();
    tick();                                 // cycle c+3
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill:idle", {30'd0, busy_o, ready_o}, {30'd0, 1'b0, 1'b1});
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (valid_o) seen++;
      tick();
    end
    check("kill:no_valid", W'(seen), W'(0));
    run_op("post_kill", 32'hC0FFEE11, 7, 1'b0, 1'b1, 0);

    // kill in DONE discards the result
    accept(32'h0000ABCD, 0, 1'b1, 1'b0);
    check("kill_done:valid_pre", W'(valid_o), W'(1));
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_done:discard", {30'd0, valid_o, busy_o}, '0);

    // kill blocks acceptance in IDLE
    valid_i = 1'b1;
    kill_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    kill_i  = 1'b0;
    check("kill_idle:no_accept", W'(busy_o), W'(0));

    // ---------------- reset mid-shift ----------------
    accept(32'h55AA55AA, 15, 1'b1, 1'b0);
    repeat (4) tick();
    rst_ni = 1'b0;
    #1;
    check("rst_mid:ready_low", W'(ready_o), W'(0));
    tick();
    check("rst_mid:state", {29'd0, valid_o, busy_o, ready_o}, '0);
    check("rst_mid:result", result_o, '0);
    rst_ni = 1'b1;
    #1;
    check("rst_mid:ready_release", W'(ready_o), W'(1));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o) seen++;
      tick();
    end
    check("rst_mid:no_stale", W'(seen), W'(0));

    // ---------------- randomized ----------------
    for (int n = 0; n < 40; n++) begin
      run_op("rand", $urandom, int'($urandom_range(W - 1, 0)),
             1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
